// File: rtl/apb2axi_pkg.sv
// Shared AXI-side types for the APB-to-AXI bridge: the completion entry
// handed from response collection to the completion FIFO.
package apb2axi_pkg;

  typedef struct packed {
    logic        is_write;
    logic [3:0]  tag;
    logic [1:0]  resp;
    logic [7:0]  beats;
    logic [31:0] rdata;
  } completion_entry_t;

  localparam int unsigned CPL_W = $bits(completion_entry_t);

endpackage

// File: rtl/apb2axi_cpl_arbiter.sv
// Merges read and write completion streams into one registered push port,
// each source behind its own small FIFO. Optional macro APB2AXI_CPL_ARB_RR_EN
// selects round-robin tie-break; otherwise reads win every tie.
module apb2axi_cpl_arbiter
  import apb2axi_pkg::*;
#(
  parameter int unsigned SRC_DEPTH = 2
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           rd_cpl_vld,
  input  completion_entry_t              rd_cpl_data,
  output logic                           rd_cpl_rdy,
  input  logic                           wr_cpl_vld,
  input  completion_entry_t              wr_cpl_data,
  output logic                           wr_cpl_rdy,
  output logic                           cq_push_vld,
  output completion_entry_t              cq_push_data,
  input  logic                           cq_push_rdy,
  output logic [$clog2(SRC_DEPTH+1)-1:0] rd_occ,
  output logic [$clog2(SRC_DEPTH+1)-1:0] wr_occ
);

  localparam int unsigned PTR_W = $clog2(SRC_DEPTH);
  localparam int unsigned OCC_W = $clog2(SRC_DEPTH + 1);
  localparam bit SRC_RD = 1'b0;
  localparam bit SRC_WR = 1'b1;

  // Index 0 is the read source, index 1 the write source.
  completion_entry_t mem [2][SRC_DEPTH];
  completion_entry_t din [2];
  logic [PTR_W-1:0]  wptr [2];
  logic [PTR_W-1:0]  rptr [2];
  logic [OCC_W-1:0]  occ  [2];
  logic [1:0]        vld_in;
  logic [1:0]        rdy;
  logic [1:0]        not_empty;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic              stage_free;

  assign vld_in      = {wr_cpl_vld, rd_cpl_vld};
  assign din[SRC_RD] = rd_cpl_data;
  assign din[SRC_WR] = wr_cpl_data;
  assign rd_cpl_rdy  = rdy[SRC_RD];
  assign wr_cpl_rdy  = rdy[SRC_WR];
  assign rd_occ      = occ[SRC_RD];
  assign wr_occ      = occ[SRC_WR];

  // Ready depends only on registered occupancy, so a full buffer stays closed even while popped.
  always_comb begin
    rdy       = '0;
    not_empty = '0;
    push      = '0;
    for (int s = 0; s < 2; s++) begin
      rdy[s]       = (occ[s] != OCC_W'(SRC_DEPTH));
      not_empty[s] = (occ[s] != '0);
      push[s]      = vld_in[s] && rdy[s];
    end
  end

`ifdef APB2AXI_CPL_ARB_RR_EN
  typedef enum logic {LAST_RD = 1'b0, LAST_WR = 1'b1} last_grant_e;
  last_grant_e last_q;
  last_grant_e last_d;

  always_ff @(posedge aclk) begin
    if (!aresetn) last_q <= LAST_WR;
    else          last_q <= last_d;
  end
`endif

  // Grant selection: a pop happens only when the output stage can take the entry.
  always_comb begin
    pop        = '0;
    stage_free = !cq_push_vld || cq_push_rdy;
`ifdef APB2AXI_CPL_ARB_RR_EN
    last_d = last_q;
    if (stage_free) begin
      if (not_empty[SRC_RD] && (!not_empty[SRC_WR] || last_q == LAST_WR)) begin
        pop[SRC_RD] = 1'b1;
        last_d      = LAST_RD;
      end else if (not_empty[SRC_WR]) begin
        pop[SRC_WR] = 1'b1;
        last_d      = LAST_WR;
      end
    end
`else
    if (stage_free) begin
      if (not_empty[SRC_RD])      pop[SRC_RD] = 1'b1;
      else if (not_empty[SRC_WR]) pop[SRC_WR] = 1'b1;
    end
`endif
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int s = 0; s < 2; s++) begin
        wptr[s] <= '0;
        rptr[s] <= '0;
        occ[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wptr[s] <= wptr[s] + PTR_W'(1);
        if (pop[s])  rptr[s] <= rptr[s] + PTR_W'(1);
        occ[s] <= occ[s] + OCC_W'(push[s]) - OCC_W'(pop[s]);
      end
    end
  end

  // Storage carries no reset; validity is tracked by pointers and occupancy.
  always_ff @(posedge aclk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem[s][wptr[s]] <= din[s];
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cq_push_vld  <= 1'b0;
      cq_push_data <= '0;
    end else if (stage_free) begin
      cq_push_vld <= |pop;
      if (pop[SRC_RD])      cq_push_data <= mem[SRC_RD][rptr[SRC_RD]];
      else if (pop[SRC_WR]) cq_push_data <= mem[SRC_WR][rptr[SRC_WR]];
    end
  end

endmodule

// File: doc/apb2axi_cpl_arbiter.md
# apb2axi_cpl_arbiter

Arbitrates between the read-completion stream (from RLAST handling) and the write-completion stream (from the B channel) into the single completion FIFO push port. Each source gets a small elastic buffer, so a read completion and a write completion arriving in the same cycle are both kept and neither overwrites the other. Sits between the AXI response collection logic and the completion FIFO on the AXI clock domain. Entries use `completion_entry_t` and `CPL_W` from `apb2axi_pkg` and pass through unmodified.

## Interface
- `SRC_DEPTH`, default 2: entries per source buffer; power of two, ≥2.
- `aclk`  in  1  AXI clock; single clock domain.
- `aresetn`  in  1  synchronous, active-low reset.
- `rd_cpl_vld`  in  1  read completion valid.
- `rd_cpl_data`  in  CPL_W  read completion entry (`completion_entry_t`, `is_write`=0).
- `rd_cpl_rdy`  out  1  read buffer not full.
- `wr_cpl_vld`  in  1  write completion valid.
- `wr_cpl_data`  in  CPL_W  write completion entry (`is_write`=1).
- `wr_cpl_rdy`  out  1  write buffer not full.
- `cq_push_vld`  out  1  completion FIFO push valid; registered.
- `cq_push_data`  out  CPL_W  completion FIFO push data; registered.
- `cq_push_rdy`  in  1  completion FIFO ready.
- `rd_occ`  out  $clog2(SRC_DEPTH+1)  read buffer occupancy.
- `wr_occ`  out  $clog2(SRC_DEPTH+1)  write buffer occupancy.

## Operation
- Per-source circular FIFO:
  - `SRC_DEPTH` entries, write/read pointers of width $clog2(SRC_DEPTH), natural wrap, plus an occupancy counter.
  - Accept on `x_cpl_vld && x_cpl_rdy`.
  - `x_cpl_rdy` = (occupancy != SRC_DEPTH), from registered state only. A full buffer deasserts rdy even in a cycle where it is also popped.
- Output stage: one register holding `cq_push_vld`/`cq_push_data`.
  - The stage is free when `!cq_push_vld || cq_push_rdy`.
  - When the stage is free and at least one buffer is non-empty, the arbiter grants one source, pops its head and loads the stage.
  - When the stage is free and both buffers are empty, `cq_push_vld` goes to 0.
- Arbiter states: `LAST_RD` and `LAST_WR` (a 1-bit last-grant register).
  - Only one buffer non-empty: grant it.
  - Both non-empty: grant the source not equal to last-grant (round-robin).
  - Every grant updates last-grant.
- Data passes through bit-exact; no field is altered or checked.
- Same-cycle push and pop on one buffer: occupancy unchanged, both pointers advance.

## Timing
- Reset values:
  - `cq_push_vld`=0, `cq_push_data`='0.
  - `rd_cpl_rdy`=`wr_cpl_rdy`=1 (after the reset cycle).
  - `rd_occ`=`wr_occ`=0, pointers 0.
  - Last-grant=`LAST_WR`, so a read wins the first tie.
- Reset asserted mid-operation: all buffered entries are discarded, the output stage is cleared, and none of them is pushed.
- Latency: an entry accepted at edge E, into an empty buffer with a free stage, gives `cq_push_vld`=1 after edge E+1.
- Throughput: one completion per cycle sustained while `cq_push_rdy`=1.
- Backpressure: while `cq_push_vld && !cq_push_rdy`, `cq_push_data` holds stable and no pop occurs.
- `rd_occ`/`wr_occ` reflect the registered counters and update one cycle after a push or pop.

## Configuration
- `APB2AXI_CPL_ARB_RR_EN` defined: round-robin tie-break as above.
- Not defined: fixed priority, reads always win a tie.
  - Last-grant is unused.
  - Writes are served only when the read buffer is empty.

## Test plan
- Reset, no traffic:
  - `cq_push_vld`=0; both rdy=1; occupancies 0.
- Single read (tag 3, 4 beats) pushed at edge E:
  - `cq_push_vld`=1 after E+1 with identical data.
  - `rd_occ` returns to 0.
- Read tag 2 and write tag 5 offered in the same cycle, `cq_push_rdy`=1:
  - Both accepted.
  - Pushes in consecutive cycles: read first (reset last-grant=WR), then write.
  - No entry lost.
- `cq_push_rdy`=0 for 6 cycles while 3 reads and 3 writes are offered:
  - Each buffer fills to 2, then rdy=0; output data is stable.
  - On release, with RR_EN, the order alternates; 6 total pushes, per-source order preserved.
- Same as above without RR_EN:
  - All queued reads are drained before any write.
- Reset asserted with both buffers full and `cq_push_vld`=1:
  - The next cycle has `cq_push_vld`=0 and occupancies 0.
  - No stale entry appears afterward.
